// File: rtl/mxu_sequencer_pkg.sv
// Shared definitions for the MXU sequencer: FSM state encoding, precision-select
// width, default array geometry and the latched core configuration record.
package mxu_sequencer_pkg;

   localparam int LOG_ALLOWED_PRECISIONS = 3;
   localparam int DEFAULT_M              = 3;
   localparam int DEFAULT_K              = 3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } seq_state_e;

   typedef struct packed {
      logic [LOG_ALLOWED_PRECISIONS-1:0] data_type;
      logic [1:0]                        fp_unit;
      logic                              chain;
   } core_cfg_t;

endpackage

// File: rtl/mxu_sequencer_valid_pipe.sv
// Enable-gated valid tracker: a DEPTH-deep shift register whose tail bit marks a
// result leaving the MXU. A clear has priority over the enable.
module mxu_valid_pipe #(
   parameter int DEPTH = 6
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] pipe_q;
   logic [DEPTH-1:0] pipe_d;

   always_comb begin
      // NOTE: default assigned first so every path drives pipe_d and no latch is inferred.
      pipe_d = pipe_q;
      if (clr) begin
         pipe_d = '0;
      end else if (en) begin
         pipe_d = (pipe_q << 1) | DEPTH'(din);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: flops take non-blocking assignments; this small vector is reset because a stale bit would fake a result.
      if (!reset) begin
         pipe_q <= '0;
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/mxu_sequencer.sv
// Job sequencer for an M x K MXU: latches config, clears the array, streams cfg_len
// vectors and drains results. Define MXU_SEQ_PERF_EN to add perf_busy/perf_stall.
module mxu_sequencer
   import mxu_sequencer_pkg::*;
#(
   parameter int M        = DEFAULT_M,
   parameter int K        = DEFAULT_K,
   parameter int PIPE_LAT = M + K,
   parameter int LEN_W    = 16
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [LEN_W-1:0]                  cfg_len,
   input  logic [LOG_ALLOWED_PRECISIONS-1:0] cfg_data_type,
   input  logic [1:0]                        cfg_fp_unit,
   input  logic                              cfg_chain,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic                              core_enable,
   output logic                              core_sclr,
   output logic [LOG_ALLOWED_PRECISIONS-1:0] core_data_type,
   output logic [1:0]                        core_fp_unit,
   output logic                              core_chain,
   output logic                              busy,
   output logic                              done
`ifdef MXU_SEQ_PERF_EN
   ,
   output logic [31:0]                       perf_busy,
   output logic [31:0]                       perf_stall
`endif
);

   seq_state_e       state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] in_cnt_q, in_cnt_d;
   logic [LEN_W-1:0] out_cnt_q, out_cnt_d;
   core_cfg_t        cfg_q, cfg_d;
   logic             pipe_tail;
   logic             beat;
   logic             out_hs;
   logic             start_acc;

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      in_cnt_d    = in_cnt_q;
      out_cnt_d   = out_cnt_q;
      cfg_d       = cfg_q;
      in_ready    = 1'b0;
      core_enable = 1'b0;
      core_sclr   = 1'b0;
      done        = 1'b0;
      beat        = 1'b0;
      start_acc   = 1'b0;
      busy        = (state_q != ST_IDLE);
      out_valid   = pipe_tail;
      out_hs      = pipe_tail && out_ready;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               start_acc       = 1'b1;
               cfg_d.data_type = cfg_data_type;
               cfg_d.fp_unit   = cfg_fp_unit;
               cfg_d.chain     = cfg_chain;
               len_d           = cfg_len;
               state_d         = (cfg_len == '0) ? ST_DONE : ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            core_sclr   = 1'b1;
            core_enable = 1'b1;
            in_cnt_d    = '0;
            out_cnt_d   = '0;
            state_d     = ST_STREAM;
         end
         ST_STREAM: begin
            in_ready = out_ready;
            beat     = in_valid && out_ready;
            // A bubble still advances the array while a result sits at the tail, so it is consumed once.
            core_enable = out_ready && (in_valid || pipe_tail);
            if (out_hs) begin
               out_cnt_d = out_cnt_q + LEN_W'(1);
            end
            if (beat) begin
               in_cnt_d = in_cnt_q + LEN_W'(1);
               if (in_cnt_d == len_q) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            core_enable = out_ready;
            if (out_hs) begin
               out_cnt_d = out_cnt_q + LEN_W'(1);
               if (out_cnt_d == len_q) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (!reset) begin
         state_d     = ST_IDLE;
         len_d       = '0;
         in_cnt_d    = '0;
         out_cnt_d   = '0;
         cfg_d       = '0;
         busy        = 1'b0;
         done        = 1'b0;
         in_ready    = 1'b0;
         out_valid   = 1'b0;
         out_hs      = 1'b0;
         core_enable = 1'b0;
         core_sclr   = 1'b1;
         beat        = 1'b0;
         start_acc   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         len_q     <= '0;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         cfg_q     <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         cfg_q     <= cfg_d;
      end
   end

   assign core_data_type = cfg_q.data_type;
   assign core_fp_unit   = cfg_q.fp_unit;
   assign core_chain     = cfg_q.chain;

   mxu_valid_pipe #(
      .DEPTH (PIPE_LAT)
   ) u_valid_pipe (
      .clk   (clk),
      .reset (reset),
      .clr   (core_sclr),
      .en    (core_enable),
      .din   (beat),
      .dout  (pipe_tail)
   );

`ifdef MXU_SEQ_PERF_EN
   logic [31:0] perf_busy_q, perf_busy_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   always_comb begin
      perf_busy_d  = perf_busy_q;
      perf_stall_d = perf_stall_q;
      if (start_acc) begin
         perf_busy_d  = '0;
         perf_stall_d = '0;
      end else begin
         if (busy && (perf_busy_q != '1)) begin
            perf_busy_d = perf_busy_q + 32'd1;
         end
         if ((state_q == ST_STREAM || state_q == ST_DRAIN) && !core_enable &&
             (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_busy_q  <= '0;
         perf_stall_q <= '0;
      end else begin
         perf_busy_q  <= perf_busy_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_busy  = perf_busy_q;
   assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_mxu_sequencer.sv
// Self-checking bench for mxu_sequencer: directed timing scenarios plus randomized
// jobs checked cycle by cycle against a queue-of-ages reference model.
module tb_mxu_sequencer;
   import mxu_sequencer_pkg::*;

   localparam int PW       = LOG_ALLOWED_PRECISIONS;
   localparam int PIPE_LAT = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [15:0]   cfg_len;
   logic [PW-1:0] cfg_data_type;
   logic [1:0]    cfg_fp_unit;
   logic          cfg_chain;
   logic          in_valid;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   logic          core_enable;
   logic          core_sclr;
   logic [PW-1:0] core_data_type;
   logic [1:0]    core_fp_unit;
   logic          core_chain;
   logic          busy;
   logic          done;
`ifdef MXU_SEQ_PERF_EN
   logic [31:0]   perf_busy;
   logic [31:0]   perf_stall;
`endif

   int checks   = 0;
   int failures = 0;

   logic ov_log  [64];
   logic ce_log  [64];
   logic dn_log  [64];
   logic bz_log  [64];
   logic ir_log  [64];
   logic sc_log  [64];
   logic ohs_log [64];
   logic ihs_log [64];
   logic [PW-1:0] cdt_log [64];

   always #5 clk = ~clk;

   mxu_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .cfg_len        (cfg_len),
      .cfg_data_type  (cfg_data_type),
      .cfg_fp_unit    (cfg_fp_unit),
      .cfg_chain      (cfg_chain),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .core_enable    (core_enable),
      .core_sclr      (core_sclr),
      .core_data_type (core_data_type),
      .core_fp_unit   (core_fp_unit),
      .core_chain     (core_chain),
      .busy           (busy),
      .done           (done)
`ifdef MXU_SEQ_PERF_EN
      ,
      .perf_busy      (perf_busy),
      .perf_stall     (perf_stall)
`endif
   );

   // Runs one job from IDLE; bit c of each mask applies to cycle c (cycle 0 = start cycle).
   task automatic run_job(input int len, input logic [63:0] iv_off, input logic [63:0] or_off,
                          input logic [63:0] st_mask, input logic [63:0] rst_low, input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk);
         #1;
         reset         = ~rst_low[c];
         start         = st_mask[c];
         cfg_len       = (c == 0) ? 16'(len) : 16'(len + 3);
         cfg_data_type = (c == 0) ? PW'(5) : PW'(2);
         cfg_fp_unit   = (c == 0) ? 2'd2 : 2'd1;
         cfg_chain     = (c == 0);
         in_valid      = ~iv_off[c];
         out_ready     = ~or_off[c];
         @(negedge clk);
         ov_log[c]  = out_valid;
         ce_log[c]  = core_enable;
         dn_log[c]  = done;
         bz_log[c]  = busy;
         ir_log[c]  = in_ready;
         sc_log[c]  = core_sclr;
         ohs_log[c] = out_valid && out_ready;
         ihs_log[c] = in_ready && in_valid;
         cdt_log[c] = core_data_type;
      end
      start     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      reset     = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (core_enable !== 1'b0) begin failures++; $display("FAIL reset_core_enable got=%b exp=0", core_enable); end
      checks++; if (core_sclr !== 1'b1) begin failures++; $display("FAIL reset_core_sclr got=%b exp=1", core_sclr); end
      checks++; if (core_data_type !== PW'(0)) begin failures++; $display("FAIL reset_cfg got=%0d exp=0", core_data_type); end
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      checks++; if (core_sclr !== 1'b0) begin failures++; $display("FAIL idle_core_sclr got=%b exp=0", core_sclr); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_basic();
      run_job(4, 64'h0, 64'h0, 64'h21, 64'h0, 16);
      for (int c = 0; c < 16; c++) begin
         checks++; if (ov_log[c] !== (c >= 8 && c <= 11)) begin failures++; $display("FAIL basic_out_valid cyc=%0d got=%b exp=%b", c, ov_log[c], (c >= 8 && c <= 11)); end
         checks++; if (ihs_log[c] !== (c >= 2 && c <= 5)) begin failures++; $display("FAIL basic_beat cyc=%0d got=%b exp=%b", c, ihs_log[c], (c >= 2 && c <= 5)); end
         checks++; if (dn_log[c] !== (c == 12)) begin failures++; $display("FAIL basic_done cyc=%0d got=%b exp=%b", c, dn_log[c], (c == 12)); end
         checks++; if (bz_log[c] !== (c >= 1 && c <= 12)) begin failures++; $display("FAIL basic_busy cyc=%0d got=%b exp=%b", c, bz_log[c], (c >= 1 && c <= 12)); end
         checks++; if (sc_log[c] !== (c == 1)) begin failures++; $display("FAIL basic_sclr cyc=%0d got=%b exp=%b", c, sc_log[c], (c == 1)); end
      end
      checks++; if (cdt_log[6] !== PW'(5)) begin failures++; $display("FAIL basic_cfg_latch got=%0d exp=5", cdt_log[6]); end
   endtask

   task automatic test_stall();
      int n = 0;
      run_job(4, 64'h0, 64'h600, 64'h1, 64'h0, 17);
      for (int c = 0; c < 17; c++) begin
         n += int'(ohs_log[c]);
         checks++; if (ce_log[c] !== ((c >= 1 && c <= 8) || (c >= 11 && c <= 13))) begin failures++; $display("FAIL stall_core_enable cyc=%0d got=%b", c, ce_log[c]); end
         checks++; if (ov_log[c] !== (c >= 8 && c <= 13)) begin failures++; $display("FAIL stall_out_valid cyc=%0d got=%b exp=%b", c, ov_log[c], (c >= 8 && c <= 13)); end
         checks++; if (dn_log[c] !== (c == 14)) begin failures++; $display("FAIL stall_done cyc=%0d got=%b exp=%b", c, dn_log[c], (c == 14)); end
      end
      checks++; if (n != 4) begin failures++; $display("FAIL stall_results got=%0d exp=4", n); end
`ifdef MXU_SEQ_PERF_EN
      checks++; if (perf_stall !== 32'd2) begin failures++; $display("FAIL perf_stall got=%0d exp=2", perf_stall); end
      checks++; if (perf_busy !== 32'd14) begin failures++; $display("FAIL perf_busy got=%0d exp=14", perf_busy); end
`endif
   endtask

   task automatic test_zero_len();
      run_job(0, 64'h0, 64'h0, 64'h1, 64'h0, 5);
      for (int c = 0; c < 5; c++) begin
         checks++; if (dn_log[c] !== (c == 1)) begin failures++; $display("FAIL zero_done cyc=%0d got=%b exp=%b", c, dn_log[c], (c == 1)); end
         checks++; if (ce_log[c] !== 1'b0) begin failures++; $display("FAIL zero_core_enable cyc=%0d got=%b exp=0", c, ce_log[c]); end
         checks++; if (bz_log[c] !== (c == 1)) begin failures++; $display("FAIL zero_busy cyc=%0d got=%b exp=%b", c, bz_log[c], (c == 1)); end
      end
   endtask

   task automatic test_bubble();
      int n_out = 0;
      int n_in  = 0;
      run_job(4, 64'h18, 64'h0, 64'h1, 64'h0, 17);
      for (int c = 0; c < 17; c++) begin
         n_out += int'(ohs_log[c]);
         n_in  += int'(ihs_log[c]);
         checks++; if (ov_log[c] !== (c >= 10 && c <= 13)) begin failures++; $display("FAIL bubble_out_valid cyc=%0d got=%b exp=%b", c, ov_log[c], (c >= 10 && c <= 13)); end
         checks++; if (dn_log[c] !== (c == 14)) begin failures++; $display("FAIL bubble_done cyc=%0d got=%b exp=%b", c, dn_log[c], (c == 14)); end
      end
      checks++; if (n_out != 4) begin failures++; $display("FAIL bubble_results got=%0d exp=4", n_out); end
      checks++; if (n_in != 4) begin failures++; $display("FAIL bubble_beats got=%0d exp=4", n_in); end
   endtask

   task automatic test_reset_mid_job();
      int n = 0;
      run_job(4, 64'h0, 64'h0, 64'h1, 64'h10, 8);
      checks++; if (bz_log[4] !== 1'b0) begin failures++; $display("FAIL midrst_busy_low got=%b exp=0", bz_log[4]); end
      checks++; if (sc_log[4] !== 1'b1) begin failures++; $display("FAIL midrst_sclr got=%b exp=1", sc_log[4]); end
      checks++; if (ce_log[4] !== 1'b0) begin failures++; $display("FAIL midrst_core_enable got=%b exp=0", ce_log[4]); end
      checks++; if (ir_log[4] !== 1'b0) begin failures++; $display("FAIL midrst_in_ready got=%b exp=0", ir_log[4]); end
      for (int c = 5; c < 8; c++) begin
         checks++; if (bz_log[c] !== 1'b0) begin failures++; $display("FAIL midrst_busy cyc=%0d got=%b exp=0", c, bz_log[c]); end
         checks++; if (ov_log[c] !== 1'b0) begin failures++; $display("FAIL midrst_out_valid cyc=%0d got=%b exp=0", c, ov_log[c]); end
         checks++; if (dn_log[c] !== 1'b0) begin failures++; $display("FAIL midrst_done cyc=%0d got=%b exp=0", c, dn_log[c]); end
      end
      checks++; if (cdt_log[5] !== PW'(0)) begin failures++; $display("FAIL midrst_cfg_cleared got=%0d exp=0", cdt_log[5]); end
      run_job(2, 64'h0, 64'h0, 64'h1, 64'h0, 12);
      for (int c = 0; c < 12; c++) begin
         n += int'(ohs_log[c]);
         checks++; if (dn_log[c] !== (c == 10)) begin failures++; $display("FAIL midrst_rerun_done cyc=%0d got=%b exp=%b", c, dn_log[c], (c == 10)); end
      end
      checks++; if (n != 2) begin failures++; $display("FAIL midrst_rerun_results got=%0d exp=2", n); end
   endtask

   // Reference model: each accepted beat is an entry whose age counts enabled cycles;
   // the oldest entry is presented as a result once it has aged PIPE_LAT cycles.
   task automatic test_random();
      for (int j = 0; j < 40; j++) begin
         int len, acc, dlv, ph, c;
         int ages[$];
         logic [PW-1:0] exp_dt;
         logic [1:0]    exp_fp;
         logic          exp_ch;
         logic e_ir, e_ov, e_ce, e_dn, e_bz, mov, bt;
         len = $urandom_range(0, 10);
         acc = 0; dlv = 0; ph = 0; c = 0;
         exp_dt = '0; exp_fp = '0; exp_ch = 1'b0;
         ages.delete();
         while (ph != 4) begin
            @(posedge clk);
            #1;
            start         = (c == 0) || (ph == 2 && $urandom_range(0, 7) == 0);
            cfg_len       = (c == 0) ? 16'(len) : 16'($urandom_range(0, 20));
            cfg_data_type = PW'($urandom);
            cfg_fp_unit   = 2'($urandom);
            cfg_chain     = 1'($urandom);
            in_valid      = ($urandom_range(0, 3) != 0);
            out_ready     = ($urandom_range(0, 3) != 0);
            if (c == 0) begin
               exp_dt = cfg_data_type;
               exp_fp = cfg_fp_unit;
               exp_ch = cfg_chain;
            end
            e_ir = 1'b0; e_ov = 1'b0; e_ce = 1'b0; e_dn = 1'b0; mov = 1'b0; bt = 1'b0;
            e_bz = (ph != 0);
            case (ph)
               1: e_ce = 1'b1;
               2: begin
                  mov  = (ages.size() > 0) && (ages[0] == PIPE_LAT);
                  e_ov = mov;
                  if (acc < len) begin
                     e_ir = out_ready;
                     e_ce = out_ready && (in_valid || mov);
                  end else begin
                     e_ce = out_ready;
                  end
                  bt = e_ir && in_valid;
               end
               3: e_dn = 1'b1;
               default: ;
            endcase
            @(negedge clk);
            checks++; if (in_ready !== e_ir) begin failures++; $display("FAIL rand_in_ready job=%0d cyc=%0d got=%b exp=%b", j, c, in_ready, e_ir); end
            checks++; if (out_valid !== e_ov) begin failures++; $display("FAIL rand_out_valid job=%0d cyc=%0d got=%b exp=%b", j, c, out_valid, e_ov); end
            checks++; if (core_enable !== e_ce) begin failures++; $display("FAIL rand_core_enable job=%0d cyc=%0d got=%b exp=%b", j, c, core_enable, e_ce); end
            checks++; if (done !== e_dn) begin failures++; $display("FAIL rand_done job=%0d cyc=%0d got=%b exp=%b", j, c, done, e_dn); end
            checks++; if (busy !== e_bz) begin failures++; $display("FAIL rand_busy job=%0d cyc=%0d got=%b exp=%b", j, c, busy, e_bz); end
            if (ph == 3) begin
               checks++;
               if ({core_data_type, core_fp_unit, core_chain} !== {exp_dt, exp_fp, exp_ch}) begin
                  failures++;
                  $display("FAIL rand_cfg job=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", j,
                           core_data_type, core_fp_unit, core_chain, exp_dt, exp_fp, exp_ch);
               end
            end
            case (ph)
               0: ph = (len == 0) ? 3 : 1;
               1: ph = 2;
               2: begin
                  if (e_ce) begin
                     if (mov) begin
                        void'(ages.pop_front());
                        dlv++;
                     end
                     foreach (ages[i]) ages[i]++;
                  end
                  if (bt) begin
                     ages.push_back(1);
                     acc++;
                  end
                  if (dlv == len) ph = 3;
               end
               default: ph = 4;
            endcase
            c++;
            if (c > 400 && ph != 4) begin
               checks++;
               failures++;
               $display("FAIL rand_timeout job=%0d got=no_done exp=done", j);
               ph = 4;
            end
         end
      end
   endtask

   initial begin
      reset         = 1'b0;
      start         = 1'b0;
      cfg_len       = '0;
      cfg_data_type = '0;
      cfg_fp_unit   = '0;
      cfg_chain     = 1'b0;
      in_valid      = 1'b0;
      out_ready     = 1'b1;
      test_reset();
      test_basic();
      test_stall();
      test_zero_len();
      test_bubble();
      test_reset_mid_job();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mxu_sequencer.md
MXU_SEQUENCER -- requirements
Module: mxu_sequencer

Interface
REQ-001 SHALL have parameter M, default 3: MXU rows; y lanes = M.
REQ-002 SHALL have parameter K, default 3: MXU columns; input_data lanes = K.
REQ-003 SHALL have parameter PIPE_LAT, default 6 (M+K): core-enabled cycles from beat acceptance to valid y.
REQ-004 SHALL have parameter LEN_W, default 16: width of the vector-count field.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  synchronous, active-low.
REQ-007 start  in  1  one-cycle job request; sampled only in IDLE.
REQ-008 cfg_len  in  LEN_W  number of input vectors in the job.
REQ-009 cfg_data_type  in  `LOG_ALLOWED_PRECISIONS  precision select for the array.
REQ-010 cfg_fp_unit  in  2  FP unit enable for the array.
REQ-011 cfg_chain  in  1  DSP chain enable for the array.
REQ-012 in_valid / in_ready  in / out  1 / 1  input-vector stream handshake.
REQ-013 out_valid / out_ready  out / in  1 / 1  result stream handshake; y data comes from the core.
REQ-014 core_enable, core_sclr  out  1  drive the core's enable and reset (core_sclr is active-high).
REQ-015 core_data_type, core_fp_unit, core_chain  out  `LOG_ALLOWED_PRECISIONS / 2 / 1  latched config.
REQ-016 busy, done  out  1  busy is high outside IDLE; done is a one-cycle completion pulse.

Function
REQ-017 SHALL implement the FSM IDLE->CLEAR->STREAM->DRAIN->DONE->IDLE.
REQ-018 IDLE: on start, SHALL latch the cfg_* inputs into the core_* outputs and go to CLEAR; with cfg_len==0 it SHALL go directly to DONE with no core_enable.
REQ-019 CLEAR: exactly one cycle with core_sclr=1 and core_enable=1; this clears the valid pipe and both counters; then STREAM.
REQ-020 STREAM: in_ready = out_ready; beat accepted when in_valid&&in_ready; core_enable = in_valid&&out_ready.
REQ-021 SHALL leave STREAM for DRAIN on the cycle the cfg_len-th beat is accepted (in_cnt reaches cfg_len).
REQ-022 DRAIN: in_ready=0 and core_enable=out_ready.
REQ-023 SHALL track valids in a PIPE_LAT-deep shift register that shifts only when core_enable=1; it loads 1 on an accepted beat and 0 otherwise.
REQ-024 out_valid = tail bit; with no stalls, a beat accepted in cycle t SHALL give out_valid in cycle t+PIPE_LAT.
REQ-025 out_cnt SHALL increment on out_valid&&out_ready; when out_cnt reaches cfg_len the FSM SHALL go to DONE.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE.
REQ-027 out_ready=0 SHALL stall the whole array: core_enable=0, in_ready=0, pipe frozen, out_valid held.
REQ-028 in_valid bubbles SHALL insert no beat and produce no out_valid.
REQ-029 start outside IDLE SHALL be ignored; cfg_* changes outside IDLE SHALL have no effect.
REQ-030 Counters SHALL be LEN_W bits; wrap is impossible because the count never exceeds cfg_len.

Reset
REQ-031 reset==0 at an edge SHALL force IDLE from any state, including mid-job, and clear pipe, counters and latched config.
REQ-032 During and after reset: busy, done, in_ready, out_valid and core_enable are 0; core_sclr = ~reset (1 while reset is low), 0 in IDLE.

Configuration
REQ-033 Macro MXU_SEQ_PERF_EN defined: SHALL add outputs perf_busy[31:0] (counts cycles with busy=1) and perf_stall[31:0] (counts cycles in STREAM/DRAIN with core_enable=0).
REQ-034 Both perf counters SHALL clear on an accepted start, saturate at all-ones, and hold after DONE.
REQ-035 Macro undefined: the perf ports and logic SHALL be absent; all other behaviour is identical.

Structure
REQ-036 State encodings and default PIPE_LAT SHALL live in a shared header mxu_seq_defs.vh; precision widths come from precision_def.vh.
REQ-037 The valid shift register SHALL be one sub-module, mxu_valid_pipe (parameters DEPTH, enable-gated).

Verification
REQ-038 start, cfg_len=4, in_valid and out_ready always 1, start in cycle 0 -> CLEAR in cycle 1; beats in cycles 2-5; out_valid in cycles 8-11; done in cycle 12; busy low from cycle 13.
REQ-039 Same as REQ-038 with out_ready=0 in cycles 9-10 -> core_enable=0 and out_valid held high in cycles 9-10; 4 results; done in cycle 14.
REQ-040 cfg_len=0 -> done in cycle 1; core_enable never asserted.
REQ-041 cfg_len=4 with in_valid=0 in cycles 3-4 -> exactly 4 out_valid handshakes; no extra results; done in cycle 14.
REQ-042 reset=0 in cycle 4 mid-STREAM -> IDLE in cycle 5; busy=0; out_valid=0; a new start with cfg_len=2 completes with 2 results.
REQ-043 MXU_SEQ_PERF_EN defined, scenario REQ-039 -> perf_stall=2, perf_busy=14.
